// File: rtl/air_con_pkg.sv
// Shared encodings for the hysteresis air-conditioning controller:
// thermostat state codes and operating mode codes.
package air_con_pkg;

  // Thermostat state; the unused code 2'b11 recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10
  } state_e;

  // Operating mode selected by the user
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_HEAT = 2'b01;
  localparam logic [1:0] MODE_COOL = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  // Heating may run in heat-only or auto mode
  function automatic logic heat_allowed(input logic [1:0] mode);
    return (mode == MODE_HEAT) || (mode == MODE_AUTO);
  endfunction

  // Cooling may run in cool-only or auto mode
  function automatic logic cool_allowed(input logic [1:0] mode);
    return (mode == MODE_COOL) || (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/air_con_hyst_dwell_counter.sv
// Saturating dwell counter. Counts edges spent in the current state and
// keeps a registered flag telling whether the minimum dwell has been met.
// min_m1 is the minimum dwell minus one for the state being entered or
// held on this edge, so ge_min always refers to the state that follows.
module dwell_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] min_m1,
  output logic             ge_min
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ge_min_q, ge_min_d;

  // Next count: restart on a state change, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
    ge_min_d = (cnt_d >= min_m1);
  end

  // Count and compare flag registers; reset behaves like a fresh state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ge_min_q <= (min_m1 == '0);
    end else begin
      cnt_q    <= cnt_d;
      ge_min_q <= ge_min_d;
    end
  end

  assign ge_min = ge_min_q;

endmodule

// File: rtl/air_con_hyst.sv
// Three-state thermostat (IDLE/HEAT/COOL) with separate heat and cool
// hysteresis bands, an anti-short-cycle minimum dwell per state, and a
// mode input that can force the plant off immediately.
module air_con_hyst
  import air_con_pkg::*;
#(
  parameter int TEMP_W   = 5,
  parameter int HEAT_ON  = 18,
  parameter int HEAT_OFF = 20,
  parameter int COOL_ON  = 22,
  parameter int COOL_OFF = 20,
  parameter int MIN_RUN  = 4,
  parameter int MIN_IDLE = 2,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temperature,
  input  logic [1:0]        mode,
  output logic              heating,
  output logic              cooling,
  output logic [1:0]        state,
  output logic              lockout
);

  localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);
  localparam logic [CNT_W-1:0]  RUN_M1     = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0]  IDLE_M1    = CNT_W'(MIN_IDLE - 1);

  // Thresholds must be ordered so heat and cool entry can never coincide
  if (!((HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_OFF) && (COOL_OFF < COOL_ON))) begin : g_bad_thresholds
    $fatal(1, "air_con_hyst: thresholds must satisfy HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON");
  end

  // Dwell minimums must be non-zero and representable by the counter
  if ((MIN_RUN < 1) || (MIN_IDLE < 1) ||
      (((1 << CNT_W) - 1) < MIN_RUN) || (((1 << CNT_W) - 1) < MIN_IDLE)) begin : g_bad_dwell
    $fatal(1, "air_con_hyst: MIN_RUN/MIN_IDLE must be >= 1 and fit in CNT_W bits");
  end

  state_e           state_q, state_d;
  logic             heating_q, heating_d;
  logic             cooling_q, cooling_d;
  logic             lockout_q, lockout_d;
  logic             exit_ok;
  logic             dwell_clear;
  logic [CNT_W-1:0] dwell_min_m1;
  logic             heat_ok, cool_ok;
  logic             heat_enter, cool_enter;

  // Transition logic: forced exits first, then hysteresis moves gated by dwell
  always_comb begin
    heat_ok    = heat_allowed(mode);
    cool_ok    = cool_allowed(mode);
    heat_enter = heat_ok && (temperature <= HEAT_ON_T);
    cool_enter = cool_ok && (temperature >= COOL_ON_T);
    state_d    = state_q;
    lockout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (heat_enter || cool_enter) begin
          if (!exit_ok) begin
            lockout_d = 1'b1;
          end else if (heat_enter) begin
            state_d = ST_HEAT;
          end else begin
            state_d = ST_COOL;
          end
        end
      end
      ST_HEAT: begin
        if (!heat_ok) begin
          state_d = ST_IDLE;
        end else if (temperature >= HEAT_OFF_T) begin
          if (exit_ok) state_d = ST_IDLE;
          else         lockout_d = 1'b1;
        end
      end
      ST_COOL: begin
        if (!cool_ok) begin
          state_d = ST_IDLE;
        end else if (temperature <= COOL_OFF_T) begin
          if (exit_ok) state_d = ST_IDLE;
          else         lockout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    heating_d    = (state_d == ST_HEAT);
    cooling_d    = (state_d == ST_COOL);
    dwell_clear  = (state_d != state_q);
    dwell_min_m1 = (rst || (state_d == ST_IDLE)) ? IDLE_M1 : RUN_M1;
  end

  // State and registered output flops; reset drops the drives at once
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      heating_q <= 1'b0;
      cooling_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      heating_q <= heating_d;
      cooling_q <= cooling_d;
      lockout_q <= lockout_d;
    end
  end

  dwell_counter #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (dwell_clear),
    .min_m1(dwell_min_m1),
    .ge_min(exit_ok)
  );

  assign state   = state_q;
  assign heating = heating_q;
  assign cooling = cooling_q;
  assign lockout = lockout_q;

endmodule

// File: tb/tb_air_con_hyst.sv
// Directed bench for air_con_hyst. The driver applies one vector per cycle
// and queues the hand-derived outputs expected after that edge; a monitor
// pops the queue one cycle later and compares against the DUT.
module tb_air_con_hyst;
  import air_con_pkg::*;

  typedef struct packed {
    logic [1:0] st;
    logic       heat;
    logic       cool;
    logic       lock;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] temperature;
  logic [1:0] mode;
  logic       heating;
  logic       cooling;
  logic [1:0] state;
  logic       lockout;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;
  int   vec_idx;

  air_con_hyst dut (
    .clk        (clk),
    .rst        (rst),
    .temperature(temperature),
    .mode       (mode),
    .heating    (heating),
    .cooling    (cooling),
    .state      (state),
    .lockout    (lockout)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one vector at the falling edge and queue the result expected after the next rising edge
  task automatic applyStimulus(input logic r, input logic [1:0] m, input logic [4:0] t,
                               input logic [1:0] st, input logic lk);
    exp_t e;
    @(negedge clk);
    rst         = r;
    mode        = m;
    temperature = t;
    e.st   = st;
    e.heat = (st == ST_HEAT);
    e.cool = (st == ST_COOL);
    e.lock = lk;
    exp_q.push_back(e);
  endtask

  // Hold steady inputs for several cycles with a constant expected state and no lockout
  task automatic holdFor(input logic [1:0] m, input logic [4:0] t, input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, m, t, st, 1'b0);
  endtask

  // Compare DUT outputs against one queued expectation, plus the never-both-drives rule
  task automatic checkOutput(input exp_t e);
    exp_t act;
    act = '{st: state, heat: heating, cool: cooling, lock: lockout};
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL vec%0d outputs: got state=%b heat=%b cool=%b lock=%b, want state=%b heat=%b cool=%b lock=%b",
               vec_idx, act.st, act.heat, act.cool, act.lock, e.st, e.heat, e.cool, e.lock);
    end
    compared++;
    if (heating && cooling) begin
      mismatched++;
      $display("[TB] FAIL vec%0d exclusive_drive: got heating=%b cooling=%b, want not both 1",
               vec_idx, heating, cooling);
    end
    vec_idx++;
  endtask

  // Monitor: sample one unit after each rising edge and check any pending expectation
  initial begin
    vec_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Directed scenario sequence with hand-computed expectations
  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    mode        = MODE_AUTO;
    temperature = 5'd24;

    // Reset, then IDLE minimum dwell blocks COOL for one cycle
    repeat (3) applyStimulus(1'b1, MODE_AUTO, 5'd24, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_AUTO, 5'd24, ST_IDLE, 1'b1);
    applyStimulus(1'b0, MODE_AUTO, 5'd24, ST_COOL, 1'b0);

    // COOL held for its full minimum run even though it wants to leave
    repeat (3) applyStimulus(1'b0, MODE_AUTO, 5'd20, ST_COOL, 1'b1);
    applyStimulus(1'b0, MODE_AUTO, 5'd20, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_AUTO, 5'd23, ST_IDLE, 1'b1);
    applyStimulus(1'b0, MODE_AUTO, 5'd23, ST_COOL, 1'b0);

    // Temperature sweep through both hysteresis bands in auto mode
    holdFor(MODE_AUTO, 5'd24, 10, ST_COOL);
    holdFor(MODE_AUTO, 5'd22, 10, ST_COOL);
    holdFor(MODE_AUTO, 5'd20, 10, ST_IDLE);
    holdFor(MODE_AUTO, 5'd18, 10, ST_HEAT);
    holdFor(MODE_AUTO, 5'd16, 10, ST_HEAT);
    holdFor(MODE_AUTO, 5'd18, 10, ST_HEAT);
    holdFor(MODE_AUTO, 5'd20, 10, ST_IDLE);
    holdFor(MODE_AUTO, 5'd22, 10, ST_COOL);

    // Enter HEAT, then force it off with mode OFF at dwell zero
    applyStimulus(1'b0, MODE_AUTO, 5'd20, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_AUTO, 5'd16, ST_IDLE, 1'b1);
    applyStimulus(1'b0, MODE_AUTO, 5'd16, ST_HEAT, 1'b0);
    applyStimulus(1'b0, MODE_OFF,  5'd16, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_OFF,  5'd16, ST_IDLE, 1'b0);

    // Heat-only mode ignores a hot room
    holdFor(MODE_HEAT, 5'd25, 20, ST_IDLE);

    // Reset in the middle of COOL, then re-entry two edges after release
    applyStimulus(1'b0, MODE_AUTO, 5'd25, ST_COOL, 1'b0);
    repeat (2) applyStimulus(1'b0, MODE_AUTO, 5'd25, ST_COOL, 1'b0);
    applyStimulus(1'b1, MODE_AUTO, 5'd25, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_AUTO, 5'd25, ST_IDLE, 1'b1);
    applyStimulus(1'b0, MODE_AUTO, 5'd25, ST_COOL, 1'b0);

    // Opposite single mode forces COOL out; then HEAT minimum run lockout
    applyStimulus(1'b0, MODE_HEAT, 5'd25, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_HEAT, 5'd15, ST_IDLE, 1'b1);
    applyStimulus(1'b0, MODE_HEAT, 5'd15, ST_HEAT, 1'b0);
    repeat (3) applyStimulus(1'b0, MODE_HEAT, 5'd21, ST_HEAT, 1'b1);
    applyStimulus(1'b0, MODE_HEAT, 5'd21, ST_IDLE, 1'b0);

    // Threshold edges: 21 enters nothing, cool-only ignores cold, 22 enters COOL, 21 holds it
    applyStimulus(1'b0, MODE_AUTO, 5'd21, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_COOL, 5'd10, ST_IDLE, 1'b0);
    applyStimulus(1'b0, MODE_COOL, 5'd22, ST_COOL, 1'b0);
    applyStimulus(1'b0, MODE_COOL, 5'd21, ST_COOL, 1'b0);

    // Let the monitor drain the queue, then report
    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
